axis_sc_mapper: RTL and testbench

//  Subcarrier mapper sitting directly downstream of the AXI-Stream sample FIFO.

---
 rtl/axis_sc_mapper.sv | 143 ++++++++++++++
 tb/tb_axis_sc_mapper.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_sc_mapper.sv
// Subcarrier mapper: one input frame of NSC samples becomes an NFFT-beat frame with GLO leading zeros, then the samples, then trailing zeros.
// Latency: one registered output stage; an input beat accepted in ACTIVE appears on m_tvalid one cycle later.
// Backpressure: the output register advances on !m_tvalid || m_tready; s_tready follows that advance in ACTIVE and is forced high in DROP.
module axis_sc_mapper #(
  parameter int DW   = 16,
  parameter int NFFT = 1024,
  parameter int NSC  = 839,
  parameter int GLO  = 93,
  parameter int CW   = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          err_short,
  output logic          err_long
);

  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, TAIL, DROP} state_t;

  localparam logic [CW-1:0] IDX_LAST = CW'(NFFT - 1);
  localparam logic [CW-1:0] GLO_LAST = CW'((GLO > 0) ? GLO - 1 : 0);
  localparam logic [CW-1:0] NSC_LAST = CW'(NSC - 1);

  state_t        state;
  logic [CW-1:0] idx;
  logic [CW-1:0] k;
  logic          drop_pend;

  logic adv;
  logic k_full;
  logic go_long;
  logic idx_end;

  assign adv      = !m_tvalid || m_tready;
  assign s_tready = ((state == ACTIVE) && adv) || (state == DROP);
  // k counts beats accepted before the current one, so k == NSC-1 means this beat is the NSC-th.
  assign k_full   = (k == NSC_LAST);
  assign go_long  = k_full && !s_tlast;
  assign idx_end  = (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      k         <= '0;
      drop_pend <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata   <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        IDLE: begin
          if (adv) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
          if (s_tvalid) begin
            k     <= '0;
            state <= (GLO > 0) ? LEAD : ACTIVE;
          end
        end

        LEAD: begin
          if (adv) begin
            m_tvalid <= 1'b1;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            idx      <= idx + 1'b1;
            if (idx == GLO_LAST) state <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (adv) begin
            if (s_tvalid) begin
              m_tvalid <= 1'b1;
              m_tdata  <= s_tdata;
              m_tlast  <= idx_end;
              k        <= k + 1'b1;
              if (s_tlast || k_full) begin
                err_short <= !k_full;
                err_long  <= go_long;
                drop_pend <= go_long;
                // With no tail guard the last active beat closes the output frame itself.
                if (idx_end) begin
                  idx   <= '0;
                  state <= go_long ? DROP : IDLE;
                end else begin
                  idx   <= idx + 1'b1;
                  state <= TAIL;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
            end
          end
        end

        TAIL: begin
          if (adv) begin
            m_tvalid <= 1'b1;
            m_tdata  <= '0;
            m_tlast  <= idx_end;
            if (idx_end) begin
              idx   <= '0;
              state <= drop_pend ? DROP : IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DROP: begin
          if (adv) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
          if (s_tvalid && s_tlast) begin
            drop_pend <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sc_mapper.sv
// Bench for axis_sc_mapper: table of frame scenarios plus random frames, checked against a frame-level reference model.
module tb_axis_sc_mapper;

  localparam int DW   = 16;
  localparam int NFFT = 1024;
  localparam int NSC  = 839;
  localparam int GLO  = 93;
  localparam int CW   = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          err_short;
  logic          err_long;

  always #5 clk = ~clk;

  axis_sc_mapper #(.DW(DW), .NFFT(NFFT), .NSC(NSC), .GLO(GLO), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .err_short(err_short), .err_long(err_long)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct {
    int len;
    int nfr;
    int pct;
    bit rnd;
    int exp_short;
    int exp_long;
  } vec_t;

  beat_t in_q[$];
  beat_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int got_beats, got_lasts, got_short, got_long;
  int mdl_short, mdl_long;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: GLO zeros, the first min(len,NSC) samples, zeros up to NFFT, tlast on the final beat.
  task automatic push_frame(input int len, input bit rnd);
    logic [DW-1:0] smp[$];
    beat_t b;
    int nmap;
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? DW'($urandom()) : DW'(i + 1);
      b.l = (i == len - 1);
      in_q.push_back(b);
      smp.push_back(b.d);
    end
    nmap = (len < NSC) ? len : NSC;
    for (int i = 0; i < NFFT; i++) begin
      b.d = (i >= GLO && i < GLO + nmap) ? smp[i - GLO] : '0;
      b.l = (i == NFFT - 1);
      exp_q.push_back(b);
    end
    if (len < NSC) mdl_short++;
    if (len > NSC) mdl_long++;
  endtask

  task automatic clear_counts();
    got_beats = 0; got_lasts = 0; got_short = 0; got_long = 0;
    mdl_short = 0; mdl_long = 0;
  endtask

  task automatic run(input int pct, input int stop_after);
    int cyc = 0;
    bit stall = 0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    beat_t e;
    forever begin
      @(negedge clk);
      m_tready = ($urandom_range(99) < pct);
      if (in_q.size() > 0) begin
        s_tvalid = 1'b1; s_tdata = in_q[0].d; s_tlast = in_q[0].l;
      end else begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
      end
      #1;
      if (stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, pd);
        check("hold_last", m_tlast, pl);
      end
      check("err_exclusive", err_short && err_long, 0);
      if (err_short) got_short++;
      if (err_long) got_long++;
      if (m_tvalid && m_tready) begin
        got_beats++;
        if (m_tlast) got_lasts++;
        if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.d);
          check("beat_last", m_tlast, e.l);
        end
      end
      stall = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (s_tvalid && s_tready) void'(in_q.pop_front());
      cyc++;
      if (stop_after > 0 && got_beats >= stop_after) break;
      if (exp_q.size() == 0 && in_q.size() == 0) begin
        @(posedge clk);
        #1 s_tvalid = 1'b0; s_tlast = 1'b0;
        break;
      end
      if (cyc >= 20000) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: %0d cycles, %0d expected beats left", cyc, exp_q.size());
        in_q.delete(); exp_q.delete();
        s_tvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int nfr, input int es, input int el);
    check({tag, "_beats"}, got_beats, nfr * NFFT);
    check({tag, "_tlasts"}, got_lasts, nfr);
    check({tag, "_err_short"}, got_short, es);
    check({tag, "_err_long"}, got_long, el);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{839, 1, 100, 0, 0, 0};
    tbl[1] = '{839, 1,  50, 0, 0, 0};
    tbl[2] = '{500, 1, 100, 0, 1, 0};
    tbl[3] = '{900, 1, 100, 0, 0, 1};
    tbl[4] = '{839, 1, 100, 1, 0, 0};
    tbl[5] = '{839, 2, 100, 1, 0, 0};
    tbl[6] = '{  1, 1,  70, 1, 1, 0};
    tbl[7] = '{838, 1, 100, 1, 1, 0};
    tbl[8] = '{840, 1,  60, 1, 0, 1};
    tbl[9] = '{839, 2,  40, 1, 0, 0};

    rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    #3;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      clear_counts();
      for (int f = 0; f < tbl[v].nfr; f++) push_frame(tbl[v].len, tbl[v].rnd);
      run(tbl[v].pct, 0);
      check_frame($sformatf("vec%0d", v), tbl[v].nfr, tbl[v].exp_short, tbl[v].exp_long);
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1000, 1);
      clear_counts();
      push_frame(len, 1'b1);
      run($urandom_range(100, 30), 0);
      check_frame($sformatf("rnd%0d_len%0d", r, len), 1, mdl_short, mdl_long);
    end

    // Reset in the middle of the active region abandons the frame.
    clear_counts();
    push_frame(839, 1'b0);
    run(100, 400);
    #1 rst = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tlast", m_tlast, 0);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tdata", m_tdata, 0);
    in_q.delete(); exp_q.delete();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_counts();
    push_frame(839, 1'b0);
    run(100, 0);
    check_frame("post_rst", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
